// File: rtl/store_lane_packer_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_lane_packer_fsm_pkg
// Purpose  : Shared definitions for the store lane packer: store-size
//            encodings, FSM state encoding and write-strobe width derivation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package store_lane_packer_fsm_pkg;

  // Store size encodings as presented on st_size. 2'b11 is reserved and is
  // handled exactly like a word store.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Controller states.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_EXC  = 3'd4
  } state_t;

  // One strobe bit per byte lane.
  function automatic int strb_width(input int width);
    return width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_lane_pack.sv
`default_nettype none
// ============================================================================
// Module   : store_lane_pack
// Purpose  : Combinational lane packer. Narrows the register value to the
//            store size, replicates it across byte lanes and produces the
//            byte strobes for a word-aligned write. Also flags misaligned
//            half/word addresses when STORE_MISALIGN_EXC_EN is defined;
//            otherwise misaligned is tied low and the low address bits the
//            size does not need are simply ignored (force-alignment).
// Ports    : addr_lo    in  2       byte offset within the word
//            size       in  2       store size encoding
//            data       in  WIDTH   register value to store
//            wdata      out WIDTH   lane-replicated data
//            wstrb      out STRB_W  byte enables
//            misaligned out 1       address not naturally aligned for size
// Revision : 1.0 - initial release
// ============================================================================
module store_lane_pack
  import store_lane_packer_fsm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STRB_W = strb_width(WIDTH)
) (
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic [WIDTH-1:0]  data,
  output logic [WIDTH-1:0]  wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              misaligned
);

  always_comb begin
    wdata      = data;
    wstrb      = '1;
    misaligned = 1'b0;
    case (size)
      SIZE_B: begin
        wdata = {4{data[7:0]}};
        wstrb = STRB_W'(4'b0001) << addr_lo;
      end
      SIZE_H: begin
        wdata = {2{data[15:0]}};
        // addr_lo[0] is dropped here, which is what force-aligns a half.
        wstrb = STRB_W'(4'b0011) << {addr_lo[1], 1'b0};
`ifdef STORE_MISALIGN_EXC_EN
        misaligned = addr_lo[0];
`endif
      end
      default: begin
        // Word and reserved encodings: full-width write on all lanes.
`ifdef STORE_MISALIGN_EXC_EN
        misaligned = (addr_lo != 2'b00);
`endif
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_lane_packer_fsm.sv
`default_nettype none
// ============================================================================
// Module   : store_lane_packer_fsm
// Purpose  : MEM-stage store unit. Accepts one store at a time, packs the
//            data into byte lanes, and drives a single write into the dcache
//            using the addr_ok/data_ok handshake. Optional address-error
//            reporting is enabled by defining STORE_MISALIGN_EXC_EN.
// Ports    : clk, rst                      clock, synchronous active-high reset
//            st_valid/st_ready             store request handshake
//            st_addr/st_data/st_size       store request payload
//            st_done                       pulse: cache committed the store
//            st_exc/st_badvaddr            pulse + address of misaligned store
//            mem_req/mem_wr                dcache write request
//            mem_addr/mem_wdata/mem_wstrb  dcache write payload
//            mem_addr_ok/mem_data_ok       dcache handshake
// Revision : 1.0 - initial release
// ============================================================================
module store_lane_packer_fsm
  import store_lane_packer_fsm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STRB_W = strb_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [WIDTH-1:0]  st_addr,
  input  logic [WIDTH-1:0]  st_data,
  input  logic [1:0]        st_size,
  output logic              st_done,
  output logic              st_exc,
  output logic [WIDTH-1:0]  st_badvaddr,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok
);

  state_t             r_state;
  logic [WIDTH-1:0]   w_wdata;
  logic [STRB_W-1:0]  w_wstrb;
  logic               w_misaligned;

  store_lane_pack #(
    .WIDTH  (WIDTH),
    .STRB_W (STRB_W)
  ) u_lane_pack (
    .addr_lo    (st_addr[1:0]),
    .size       (st_size),
    .data       (st_data),
    .wdata      (w_wdata),
    .wstrb      (w_wstrb),
    .misaligned (w_misaligned)
  );

`ifndef STORE_MISALIGN_EXC_EN
  assign st_exc      = 1'b0;
  assign st_badvaddr = '0;
`endif

  // All outputs are registered; the packed write is captured at accept time
  // so the cache sees stable address/data/strobes for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      st_ready    <= 1'b1;
      st_done     <= 1'b0;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
`ifdef STORE_MISALIGN_EXC_EN
      st_exc      <= 1'b0;
      st_badvaddr <= '0;
`endif
    end else begin
      st_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (st_valid) begin
            st_ready  <= 1'b0;
            mem_addr  <= {st_addr[WIDTH-1:2], 2'b00};
            mem_wdata <= w_wdata;
            mem_wstrb <= w_wstrb;
            // w_misaligned is constant low without the exception feature,
            // so S_EXC is unreachable in that build.
            if (w_misaligned) begin
              r_state     <= S_EXC;
`ifdef STORE_MISALIGN_EXC_EN
              st_exc      <= 1'b1;
              st_badvaddr <= st_addr;
`endif
            end else begin
              r_state <= S_REQ;
              mem_req <= 1'b1;
              mem_wr  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
            if (mem_data_ok) begin
              r_state <= S_DONE;
              st_done <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Request already accepted; a stray addr_ok here means nothing.
          if (mem_data_ok) begin
            r_state <= S_DONE;
            st_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          st_ready <= 1'b1;
        end
        S_EXC: begin
          r_state     <= S_IDLE;
          st_ready    <= 1'b1;
`ifdef STORE_MISALIGN_EXC_EN
          st_exc      <= 1'b0;
          st_badvaddr <= '0;
`endif
        end
        default: begin
          r_state  <= S_IDLE;
          st_ready <= 1'b1;
          mem_req  <= 1'b0;
          mem_wr   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_lane_packer_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_store_lane_packer_fsm
// Purpose  : Directed self-checking bench for store_lane_packer_fsm. Expected
//            cache writes are queued when a store is issued and compared when
//            the DUT's request is accepted by the modelled cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_lane_packer_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        st_exc;
  logic [31:0] st_badvaddr;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok;
  logic        mem_data_ok;

  store_lane_packer_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .st_done     (st_done),
    .st_exc      (st_exc),
    .st_badvaddr (st_badvaddr),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_t;
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;
  int   exc_cnt  = 0;
  int   exp_done = 0;
  int   exp_exc  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    txn_t t;
    t.addr  = a;
    t.wdata = d;
    t.wstrb = s;
    exp_q.push_back(t);
  endtask

  // Present a store for one cycle; returns at the negedge of cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  // Store with immediate addr_ok & data_ok; checks minimum latency.
  task automatic quick(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic [31:0] ea, input logic [31:0] ew,
                       input logic [3:0] es);
    push(ea, ew, es);
    issue(a, d, s);
    check({tag, "_req"}, mem_req, 1);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    check({tag, "_done"}, st_done, 1);
    exp_done++;
    @(negedge clk);
    check({tag, "_ready"}, st_ready, 1);
  endtask

  // Cache-side monitor: compares the write whenever the cache accepts it.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (mem_req && mem_addr_ok) begin
        if (exp_q.size() == 0) begin
          check("req_with_empty_queue", exp_q.size(), 1);
        end else begin
          mon_t = exp_q.pop_front();
          check("mon_addr",  mem_addr,  mon_t.addr);
          check("mon_wdata", mem_wdata, mon_t.wdata);
          check("mon_wstrb", {28'd0, mem_wstrb}, {28'd0, mon_t.wstrb});
          check("mon_wr",    mem_wr,    1);
        end
      end
      if (st_done) done_cnt++;
      if (st_exc)  exc_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    st_valid    = 1'b0;
    st_addr     = '0;
    st_data     = '0;
    st_size     = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready",    st_ready,    1);
    check("rst_req",      mem_req,     0);
    check("rst_done",     st_done,     0);
    check("rst_exc",      st_exc,      0);
    check("rst_addr",     mem_addr,    0);
    check("rst_wdata",    mem_wdata,   0);
    check("rst_wstrb",    {28'd0, mem_wstrb}, 0);
    check("rst_badvaddr", st_badvaddr, 0);

    // Byte store, single-cycle handshake, done at cycle 2
    push(32'h0000_1000, 32'hDDDD_DDDD, 4'b1000);
    issue(32'h0000_1003, 32'hAABB_CCDD, 2'b00);
    check("t1_req_c1",   mem_req,  1);
    check("t1_ready_c1", st_ready, 0);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    check("t1_done_c2", st_done, 1);
    check("t1_req_c2",  mem_req, 0);
    exp_done++;
    @(negedge clk);
    check("t1_done_c3",  st_done,  0);
    check("t1_ready_c3", st_ready, 1);

    // Half store: addr_ok in cycle 1, data_ok in cycle 4 (stray addr_ok in WAIT)
    push(32'h0000_2000, 32'h5678_5678, 4'b1100);
    issue(32'h0000_2002, 32'h1234_5678, 2'b01);
    check("t2_req_c1", mem_req, 1);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    check("t2_req_c2",  mem_req, 0);
    check("t2_done_c2", st_done, 0);
    @(negedge clk);
    mem_addr_ok = 1'b1;
    check("t2_req_c3", mem_req, 0);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    check("t2_req_c4",  mem_req, 0);
    check("t2_done_c4", st_done, 0);
    @(negedge clk);
    mem_data_ok = 1'b0;
    check("t2_done_c5", st_done, 1);
    exp_done++;
    @(negedge clk);
    check("t2_done_c6", st_done, 0);

    // Word store with addr_ok withheld for 3 cycles; request must hold steady
    push(32'h0000_3000, 32'hCAFE_F00D, 4'b1111);
    issue(32'h0000_3000, 32'hCAFE_F00D, 2'b10);
    for (int i = 0; i < 3; i++) begin
      check("t3_req_hold",   mem_req,   1);
      check("t3_addr_hold",  mem_addr,  32'h0000_3000);
      check("t3_wdata_hold", mem_wdata, 32'hCAFE_F00D);
      check("t3_wstrb_hold", {28'd0, mem_wstrb}, 32'hF);
      @(negedge clk);
    end
    check("t3_req_c4", mem_req, 1);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    check("t3_done_c5", st_done, 1);
    exp_done++;
    @(negedge clk);
    check("t3_done_c6", st_done, 0);

    // Misaligned half store
`ifdef STORE_MISALIGN_EXC_EN
    issue(32'h0000_4001, 32'h0000_BEEF, 2'b01);
    check("t4_exc_c1",      st_exc,      1);
    check("t4_badvaddr_c1", st_badvaddr, 32'h0000_4001);
    check("t4_req_c1",      mem_req,     0);
    exp_exc++;
    @(negedge clk);
    check("t4_exc_c2",   st_exc,   0);
    check("t4_ready_c2", st_ready, 1);
    check("t4_done_c2",  st_done,  0);
`else
    quick("t4_half_misal", 32'h0000_4001, 32'h0000_BEEF, 2'b01,
          32'h0000_4000, 32'hBEEF_BEEF, 4'b0011);
    check("t4_exc", st_exc, 0);
`endif

    // Reset while waiting for data_ok
    push(32'h0000_6000, 32'h1122_3344, 4'b1111);
    issue(32'h0000_6000, 32'h1122_3344, 2'b10);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    check("t5_req_wait", mem_req, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ready_after_rst", st_ready, 1);
    check("t5_req_after_rst",   mem_req,  0);
    check("t5_done_after_rst",  st_done,  0);
    @(negedge clk);
    check("t5_done_later", st_done, 0);
    quick("t5_byte", 32'h0000_5001, 32'h0000_00A5, 2'b00,
          32'h0000_5000, 32'hA5A5_A5A5, 4'b0010);

    // Additional lane patterns and truncation
    quick("t6_byte0", 32'h0000_8000, 32'h1234_5677, 2'b00,
          32'h0000_8000, 32'h7777_7777, 4'b0001);
    quick("t6_half0", 32'h0000_8000, 32'hFFFF_1357, 2'b01,
          32'h0000_8000, 32'h1357_1357, 4'b0011);
    quick("t6_rsvd",  32'h0000_7000, 32'h0102_0304, 2'b11,
          32'h0000_7000, 32'h0102_0304, 4'b1111);

    // Ignored st_valid while busy: second request must not be accepted
    push(32'h0000_9000, 32'h9999_9999, 4'b1111);
    issue(32'h0000_9000, 32'h9999_9999, 2'b10);
    st_valid = 1'b1;
    st_addr  = 32'h0000_A000;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    @(negedge clk);
    st_valid    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    check("t7_done", st_done, 1);
    exp_done++;
    @(negedge clk);
    check("t7_idle_req", mem_req, 0);
    @(negedge clk);
    check("t7_no_second_req", mem_req, 0);

    #3;
    check("queue_empty", exp_q.size(), 0);
    check("done_count",  done_cnt,     exp_done);
    check("exc_count",   exc_cnt,      exp_exc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
